// File: rtl/timer_control.sv
// Egg-timer control: holds the user-entered MM:SS cook time as BCD digits,
// drives load/run to the countdown core, detects expiry and times the alarm.
module timer_control #(
  parameter int unsigned MAX_TENS_MIN = 9,
  parameter int unsigned ALARM_SECS   = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pulse_1s,
  input  logic       btn_start_stop,
  input  logic       btn_clear,
  input  logic       inc_sec,
  input  logic       dec_sec,
  input  logic       inc_min,
  input  logic       dec_min,
  input  logic [3:0] seconds,
  input  logic [3:0] tens_seconds,
  input  logic [3:0] minutes,
  input  logic [3:0] tens_minutes,
  output logic [3:0] seconds_prog,
  output logic [3:0] tens_seconds_prog,
  output logic [3:0] minutes_prog,
  output logic [3:0] tens_minutes_prog,
  output logic       timer_load,
  output logic       timer_on,
  output logic       alarm,
  output logic [1:0] state
);

  localparam int unsigned        CNT_W      = $clog2(ALARM_SECS + 1);
  localparam logic [3:0]         MAX_TM     = 4'(MAX_TENS_MIN);
  localparam logic [CNT_W-1:0]   ALARM_LAST = CNT_W'(ALARM_SECS - 1);

  typedef enum logic [1:0] {
    ST_SET   = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      prog_q, prog_d;      // {tens_min, min, tens_sec, sec}
  logic             load_q, load_d;
  logic             on_q, on_d;
  logic             alarm_q, alarm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0]  s, ts, m, tm;
  logic [15:0] edit_v;
  logic        live_zero;

  assign s  = prog_q[3:0];
  assign ts = prog_q[7:4];
  assign m  = prog_q[11:8];
  assign tm = prog_q[15:12];

  assign live_zero = ({tens_minutes, minutes, tens_seconds, seconds} == '0);

  // Edited time for the highest-priority edit pulse, with BCD carry/borrow and saturation.
  always_comb begin
    edit_v = prog_q;
    if (inc_min) begin
      if (!(tm == MAX_TM && m == 4'd9)) begin
        if (m != 4'd9) edit_v[11:8] = m + 4'd1;
        else begin
          edit_v[11:8]  = '0;
          edit_v[15:12] = tm + 4'd1;
        end
      end
    end else if (inc_sec) begin
      if (!(tm == MAX_TM && m == 4'd9 && ts == 4'd5 && s == 4'd9)) begin
        if (s != 4'd9) edit_v[3:0] = s + 4'd1;
        else begin
          edit_v[3:0] = '0;
          if (ts != 4'd5) edit_v[7:4] = ts + 4'd1;
          else begin
            edit_v[7:4] = '0;
            if (m != 4'd9) edit_v[11:8] = m + 4'd1;
            else begin
              edit_v[11:8]  = '0;
              edit_v[15:12] = tm + 4'd1;
            end
          end
        end
      end
    end else if (dec_min) begin
      if (!(tm == 4'd0 && m == 4'd0)) begin
        if (m != 4'd0) edit_v[11:8] = m - 4'd1;
        else begin
          edit_v[11:8]  = 4'd9;
          edit_v[15:12] = tm - 4'd1;
        end
      end
    end else if (dec_sec) begin
      if (prog_q != '0) begin
        if (s != 4'd0) edit_v[3:0] = s - 4'd1;
        else begin
          edit_v[3:0] = 4'd9;
          if (ts != 4'd0) edit_v[7:4] = ts - 4'd1;
          else begin
            edit_v[7:4] = 4'd5;
            if (m != 4'd0) edit_v[11:8] = m - 4'd1;
            else begin
              edit_v[11:8]  = 4'd9;
              edit_v[15:12] = tm - 4'd1;
            end
          end
        end
      end
    end
  end

  // Next-state, programmed time, load strobe and alarm counter.
  always_comb begin
    state_d = state_q;
    prog_d  = prog_q;
    load_d  = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_SET: begin
        if (btn_clear) begin
          prog_d = '0;
          load_d = 1'b1;
        end else if (btn_start_stop) begin
          if (prog_q != '0) state_d = ST_RUN;
        end else begin
          prog_d = edit_v;
          load_d = (edit_v != prog_q);
        end
      end
      ST_RUN: begin
        if (live_zero) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else if (btn_clear) begin
          state_d = ST_SET;
          load_d  = 1'b1;
        end else if (btn_start_stop) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (btn_clear) begin
          state_d = ST_SET;
          load_d  = 1'b1;
        end else if (btn_start_stop) begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (btn_clear || btn_start_stop || (pulse_1s && cnt_q == ALARM_LAST)) begin
          state_d = ST_SET;
          load_d  = 1'b1;
          cnt_d   = '0;
        end else if (pulse_1s) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_SET;
    endcase
    on_d    = (state_d == ST_RUN);
    alarm_d = (state_d == ST_DONE);
  end

  // Registered state and outputs with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_SET;
      prog_q  <= '0;
      load_q  <= 1'b0;
      on_q    <= 1'b0;
      alarm_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prog_q  <= prog_d;
      load_q  <= load_d;
      on_q    <= on_d;
      alarm_q <= alarm_d;
      cnt_q   <= cnt_d;
    end
  end

  assign seconds_prog      = prog_q[3:0];
  assign tens_seconds_prog = prog_q[7:4];
  assign minutes_prog      = prog_q[11:8];
  assign tens_minutes_prog = prog_q[15:12];
  assign timer_load        = load_q;
  assign timer_on          = on_q;
  assign alarm             = alarm_q;
  assign state             = state_q;

endmodule

// File: tb/tb_timer_control.sv
// Bench for timer_control: a seconds-based reference model plus a simple
// countdown core, directed scenarios and a randomized pulse phase.
module tb_timer_control;

  localparam int unsigned MAX_TENS_MIN = 9;
  localparam int unsigned ALARM_SECS   = 5;
  localparam int          MAX_MIN      = int'(MAX_TENS_MIN) * 10 + 9;
  localparam int          T_MAX        = MAX_MIN * 60 + 59;

  logic       clk, reset_n, pulse_1s;
  logic       btn_start_stop, btn_clear, inc_sec, dec_sec, inc_min, dec_min;
  logic [3:0] seconds, tens_seconds, minutes, tens_minutes;
  logic [3:0] seconds_prog, tens_seconds_prog, minutes_prog, tens_minutes_prog;
  logic       timer_load, timer_on, alarm;
  logic [1:0] state;

  timer_control #(.MAX_TENS_MIN(MAX_TENS_MIN), .ALARM_SECS(ALARM_SECS)) dut (
    .clk(clk), .reset_n(reset_n), .pulse_1s(pulse_1s),
    .btn_start_stop(btn_start_stop), .btn_clear(btn_clear),
    .inc_sec(inc_sec), .dec_sec(dec_sec), .inc_min(inc_min), .dec_min(dec_min),
    .seconds(seconds), .tens_seconds(tens_seconds), .minutes(minutes), .tens_minutes(tens_minutes),
    .seconds_prog(seconds_prog), .tens_seconds_prog(tens_seconds_prog),
    .minutes_prog(minutes_prog), .tens_minutes_prog(tens_minutes_prog),
    .timer_load(timer_load), .timer_on(timer_on), .alarm(alarm), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int t);
    int mm, ss;
    mm = t / 60;
    ss = t % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic int from_bcd(input logic [15:0] b);
    return (int'(b[15:12]) * 10 + int'(b[11:8])) * 60 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  logic [15:0] prog_w;
  assign prog_w = {tens_minutes_prog, minutes_prog, tens_seconds_prog, seconds_prog};

  // Countdown core stand-in: reload on timer_load, count down on enabled strobes.
  int          live_t;
  logic [15:0] live_bcd;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) live_t <= 0;
    else if (timer_load) live_t <= from_bcd(prog_w);
    else if (timer_on && pulse_1s && live_t > 0) live_t <= live_t - 1;
  end
  assign live_bcd = to_bcd(live_t);
  assign {tens_minutes, minutes, tens_seconds, seconds} = live_bcd;

  // Reference model: time as plain seconds, mode as the 0..3 state code.
  int m_t, m_st, m_cnt;
  bit m_load, m_on, m_alarm;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_t = 0; m_st = 0; m_cnt = 0; m_load = 0; m_on = 0; m_alarm = 0;
    end else begin
      m_load = 0;
      case (m_st)
        0: begin
          if (btn_clear) begin m_t = 0; m_load = 1; end
          else if (btn_start_stop) begin if (m_t != 0) m_st = 1; end
          else if (inc_min) begin if (m_t / 60 < MAX_MIN) begin m_t += 60; m_load = 1; end end
          else if (inc_sec) begin if (m_t < T_MAX) begin m_t += 1; m_load = 1; end end
          else if (dec_min) begin if (m_t / 60 > 0) begin m_t -= 60; m_load = 1; end end
          else if (dec_sec) begin if (m_t > 0) begin m_t -= 1; m_load = 1; end end
        end
        1: begin
          if (live_t == 0) begin m_st = 3; m_cnt = 0; end
          else if (btn_clear) begin m_st = 0; m_load = 1; end
          else if (btn_start_stop) m_st = 2;
        end
        2: begin
          if (btn_clear) begin m_st = 0; m_load = 1; end
          else if (btn_start_stop) m_st = 1;
        end
        default: begin
          if (btn_clear || btn_start_stop) begin m_st = 0; m_load = 1; m_cnt = 0; end
          else if (pulse_1s) begin
            m_cnt += 1;
            if (m_cnt == int'(ALARM_SECS)) begin m_st = 0; m_load = 1; m_cnt = 0; end
          end
        end
      endcase
      m_on    = (m_st == 1);
      m_alarm = (m_st == 3);
    end
  end

  // Strobe generator: at least 3 clk between strobes when enabled.
  bit pg_en;
  initial begin
    int gap;
    gap = 0;
    pulse_1s = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (pg_en && gap == 0) begin
        pulse_1s = 1'b1;
        gap = $urandom_range(2, 5);
      end else begin
        pulse_1s = 1'b0;
        if (gap > 0) gap--;
      end
    end
  end

  int checks, errors, load_cnt;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic [5:0] ops);
    {btn_clear, btn_start_stop, inc_min, inc_sec, dec_min, dec_sec} = ops;
  endtask

  // ops = {clear, start_stop, inc_min, inc_sec, dec_min, dec_sec}, held for n edges.
  task automatic press(input logic [5:0] ops, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      drive(ops);
    end
    @(posedge clk); #1;
    drive(6'b0);
  endtask

  task automatic set_time(input int mins, input int secs);
    press(6'b100000, 1);
    if (mins > 0) press(6'b001000, mins);
    if (secs > 0) press(6'b000100, secs);
  endtask

  initial begin
    int base, npulse;
    bit found, left;
    checks = 0; errors = 0; load_cnt = 0; pg_en = 0;
    drive(6'b0);
    reset_n = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (reset_n) begin
          checks++;
          if ({prog_w, timer_load, timer_on, alarm, state} !==
              {to_bcd(m_t), m_load, m_on, m_alarm, m_st[1:0]}) begin
            errors++;
            $display("FAIL cycle_model t=%0t actual prog=%h ld=%b on=%b al=%b st=%0d required prog=%h ld=%b on=%b al=%b st=%0d",
                     $time, prog_w, timer_load, timer_on, alarm, state,
                     to_bcd(m_t), m_load, m_on, m_alarm, m_st);
          end
        end
      end
      forever begin
        @(negedge clk);
        if (reset_n && timer_load) load_cnt++;
      end
    join_none

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("reset_prog", int'(prog_w), 0);
    chk("reset_outs", int'({timer_load, timer_on, alarm, state}), 0);
    #1 reset_n = 1'b1;

    // Ten inc_sec pulses
    base = load_cnt;
    for (int i = 0; i < 10; i++) press(6'b000100, 1);
    @(negedge clk); #1;
    chk("t1_prog", int'(prog_w), 'h0010);
    chk("t1_loads", load_cnt - base, 10);
    chk("t1_state", int'(state), 0);
    chk("t1_model_secs", m_t, 10);

    // Carry, saturation, borrow
    set_time(0, 59);
    press(6'b000100, 1);
    chk("t2_carry_prog", int'(prog_w), 'h0100);
    chk("t2_carry_load", int'(timer_load), 1);
    set_time(99, 59);
    chk("t2_max_prog", int'(prog_w), 'h9959);
    press(6'b000100, 1);
    chk("t2_sat_prog", int'(prog_w), 'h9959);
    chk("t2_sat_noload", int'(timer_load), 0);
    press(6'b001000, 1);
    chk("t2_satmin_noload", int'(timer_load), 0);
    set_time(0, 0);
    press(6'b000001, 1);
    chk("t2_zero_prog", int'(prog_w), 0);
    chk("t2_zero_noload", int'(timer_load), 0);
    set_time(5, 30);
    press(6'b000010, 1);
    chk("t2_decmin_prog", int'(prog_w), 'h0430);
    chk("t2_model_secs", m_t, 270);

    // Start at zero ignored; clear beats inc_sec
    set_time(0, 0);
    press(6'b010000, 1);
    chk("t3_start_zero_state", int'(state), 0);
    chk("t3_start_zero_on", int'(timer_on), 0);
    set_time(0, 5);
    press(6'b100100, 1);
    chk("t3_clear_prio_prog", int'(prog_w), 0);
    chk("t3_clear_prio_load", int'(timer_load), 1);

    // Countdown to expiry and alarm timeout
    set_time(0, 3);
    press(6'b010000, 1);
    chk("t4_run_state", int'(state), 1);
    chk("t4_run_on", int'(timer_on), 1);
    pg_en = 1;
    found = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (live_t == 0) begin found = 1; break; end
    end
    chk("t4_live_reaches_zero", int'(found), 1);
    @(posedge clk); #1;
    chk("t4_done_state", int'(state), 3);
    chk("t4_done_on", int'(timer_on), 0);
    chk("t4_done_alarm", int'(alarm), 1);
    npulse = 0; left = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (state != 2'd3) begin left = 1; break; end
      if (pulse_1s) npulse++;
    end
    chk("t4_left_done", int'(left), 1);
    chk("t4_alarm_strobes", npulse, 5);
    chk("t4_back_state", int'(state), 0);
    chk("t4_back_alarm", int'(alarm), 0);
    chk("t4_back_prog", int'(prog_w), 'h0003);
    chk("t4_back_load", int'(timer_load), 1);
    pg_en = 0;

    // Pause / resume / clear
    set_time(5, 0);
    press(6'b010000, 1);
    chk("t5_run", int'(state), 1);
    press(6'b010000, 1);
    chk("t5_pause_state", int'(state), 2);
    chk("t5_pause_on", int'(timer_on), 0);
    press(6'b000100, 1);
    chk("t5_pause_edit_prog", int'(prog_w), 'h0500);
    chk("t5_pause_edit_noload", int'(timer_load), 0);
    press(6'b010000, 1);
    chk("t5_resume_on", int'(timer_on), 1);
    press(6'b100000, 1);
    chk("t5_clear_state", int'(state), 0);
    chk("t5_clear_load", int'(timer_load), 1);
    chk("t5_clear_prog", int'(prog_w), 'h0500);

    // Asynchronous reset mid-RUN
    press(6'b010000, 1);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("t6_areset_prog", int'(prog_w), 0);
    chk("t6_areset_outs", int'({timer_load, timer_on, alarm, state}), 0);
    @(negedge clk); #2 reset_n = 1'b1;

    // Expiry coincident with start_stop
    set_time(0, 2);
    press(6'b010000, 1);
    pg_en = 1;
    found = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (live_t == 0) begin found = 1; break; end
    end
    chk("t6_live_reaches_zero", int'(found), 1);
    btn_start_stop = 1'b1;
    @(posedge clk); #1;
    btn_start_stop = 1'b0;
    chk("t6_expiry_wins", int'(state), 3);
    press(6'b100000, 1);
    chk("t6_done_clear_state", int'(state), 0);
    chk("t6_done_clear_prog", int'(prog_w), 'h0002);

    // Randomized single-pulse traffic
    for (int i = 0; i < 4000; i++) begin
      int r;
      @(posedge clk); #1;
      r = $urandom_range(0, 99);
      if      (r < 50) drive(6'b000000);
      else if (r < 70) drive(6'b000100);
      else if (r < 78) drive(6'b001000);
      else if (r < 86) drive(6'b000001);
      else if (r < 90) drive(6'b000010);
      else if (r < 96) drive(6'b010000);
      else             drive(6'b100000);
    end
    @(posedge clk); #1;
    drive(6'b0);
    pg_en = 0;
    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
